// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory request controller.
// Used by mem_ctrl, the CPU load/store unit and the bench.
//   mem_ctrl_state_e : controller FSM states
//   MEM_ADDR_W / MEM_DATA_W / MEM_DEPTH : default memory geometry (32x8)
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } mem_ctrl_state_e;

    localparam int unsigned MEM_ADDR_W = 5;
    localparam int unsigned MEM_DATA_W = 8;
    localparam int unsigned MEM_DEPTH  = 32;

endpackage

// File: rtl/mem_ctrl.sv
// Request/response front-end for the synchronous data memory (MEM).
// Accepts one load/store at a time over valid/ready, range-checks the
// address, drives MEM directly and returns exactly one registered response.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we                   1 = store, 0 = load
//   req_addr, req_wdata      word address, store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                load data (0 for stores and errors)
//   rsp_err                  address out of range (addr >= DEPTH)
//   mem_en/mem_we/mem_addr/mem_din  MEM drive
//   mem_dout                 MEM read data, valid the cycle after a read
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    mem_ctrl_state_e   state, state_d;
    logic [DATA_W-1:0] rdata_d;
    logic              err_d;
    logic              acc;
    logic              in_range;

    assign in_range  = ({1'b0, req_addr} < DEPTH_L);
    assign req_ready = (state == IDLE) & ~rst;
    assign acc       = req_valid & req_ready;

    // MEM is driven straight from the accepted request, so a store
    // commits on the same edge that accepts it.
    assign mem_en    = acc & in_range;
    assign mem_we    = mem_en & req_we;
    assign mem_addr  = req_addr;
    assign mem_din   = req_wdata;

    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        rdata_d = rsp_rdata;
        err_d   = rsp_err;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (!in_range) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // MEM dout is valid now, one cycle after the read enable.
                state_d = RESP;
                rdata_d = mem_dout;
                err_d   = 1'b0;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    a_en_only_idle: assert property (@(posedge clk) disable iff (rst)
        mem_en |-> (state == IDLE));
    a_resp_valid: assert property (@(posedge clk) disable iff (rst)
        !rsp_valid |-> (state != RESP));

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: two instances (DEPTH 32 and DEPTH 20),
// each with its own behavioural 32x8 synchronous memory. Expected results
// come from a word-array reference model and the latency rules.
module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_we    [2];
    logic [4:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_rdata [2];
    logic       rsp_err   [2];
    logic       mem_en    [2];
    logic       mem_we    [2];
    logic [4:0] mem_addr  [2];
    logic [7:0] mem_din   [2];

    int         depth_of [2] = '{32, 20};
    logic [7:0] ref_mem  [2][32];
    int         n_checks = 0;
    int         n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 32 : 20;
        logic [7:0] mem [32];
        logic [7:0] dout = '0;

        initial for (int i = 0; i < 32; i++) mem[i] = '0;

        always @(posedge clk) begin
            if (mem_en[g]) begin
                if (mem_we[g]) mem[mem_addr[g]] <= mem_din[g];
                else           dout <= mem[mem_addr[g]];
            end
        end

        mem_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(D)) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_din   (mem_din[g]),
            .mem_dout  (dout)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Garbage on the request bus while the controller is busy.
    task automatic noise(input int k);
        req_valid[k] = 1'($urandom);
        req_we[k]    = 1'($urandom);
        req_addr[k]  = 5'($urandom);
        req_wdata[k] = 8'($urandom);
    endtask

    // One full transaction on instance k, starting just after a negedge.
    task automatic txn(input int k, input bit we, input logic [4:0] addr,
                       input logic [7:0] data, input int stall);
        bit         inr     = (int'(addr) < depth_of[k]);
        logic [7:0] exp_d   = (!inr || we) ? 8'h00 : ref_mem[k][addr];
        int         exp_lat = (inr && !we) ? 2 : 1;
        int         lat     = 0;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = data;
        #1;
        chk("req_ready_idle", req_ready[k], 1);
        chk("mem_en_accept", mem_en[k], inr);
        chk("mem_we_accept", mem_we[k], inr && we);
        if (inr && we) ref_mem[k][addr] = data;
        @(posedge clk);
        @(negedge clk);
        do begin
            lat++;
            noise(k);
            #1;
            chk("req_ready_busy", req_ready[k], 0);
            chk("mem_en_busy", mem_en[k], 0);
            if (rsp_valid[k]) break;
            @(negedge clk);
        end while (lat < 8);
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_rdata", rsp_rdata[k], exp_d);
        chk("rsp_err", rsp_err[k], !inr);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            noise(k);
            #1;
            chk("stall_valid", rsp_valid[k], 1);
            chk("stall_rdata", rsp_rdata[k], exp_d);
            chk("stall_err", rsp_err[k], !inr);
            chk("stall_ready", req_ready[k], 0);
            chk("stall_mem_en", mem_en[k], 0);
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        #1;
        chk("post_hs_valid", rsp_valid[k], 0);
        chk("post_hs_ready", req_ready[k], 1);
    endtask

    initial begin
        #200000;
        $error("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b1;
            req_we[k]    = 1'b1;
            req_addr[k]  = 5'd3;
            req_wdata[k] = 8'h5A;
            rsp_ready[k] = 1'b0;
            for (int i = 0; i < 32; i++) ref_mem[k][i] = 8'h00;
        end

        // Reset state, with a pending request that must be ignored.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", rsp_valid[k], 0);
            chk("rst_rdata", rsp_rdata[k], 0);
            chk("rst_err", rsp_err[k], 0);
            chk("rst_ready", req_ready[k], 0);
            chk("rst_mem_en", mem_en[k], 0);
            req_valid[k] = 1'b0;
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk("ready_after_rst", req_ready[k], 1);

        // Directed: DEPTH 32 instance.
        txn(0, 1'b1, 5'd5,  8'hA5, 0);
        txn(0, 1'b0, 5'd5,  8'h00, 0);
        txn(0, 1'b1, 5'd0,  8'h11, 0);
        txn(0, 1'b1, 5'd31, 8'h22, 0);
        txn(0, 1'b0, 5'd31, 8'h00, 0);
        txn(0, 1'b0, 5'd0,  8'h00, 0);
        txn(0, 1'b0, 5'd31, 8'h00, 5);

        // Directed: DEPTH 20 instance, range boundaries.
        txn(1, 1'b1, 5'd19, 8'h3C, 0);
        txn(1, 1'b1, 5'd25, 8'hFF, 0);
        txn(1, 1'b0, 5'd25, 8'h00, 0);
        txn(1, 1'b1, 5'd20, 8'h77, 1);
        txn(1, 1'b0, 5'd20, 8'h00, 0);
        txn(1, 1'b0, 5'd19, 8'h00, 2);

        // Reset while the load sits in RD_WAIT: transaction is dropped.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 5'd5;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", req_ready[0], 0);
        chk("rst_mid_mem_en", mem_en[0], 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_valid", rsp_valid[0], 0);
        rst = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        chk("rst_mid_rdata", rsp_rdata[0], 0);
        chk("rst_mid_ready_after", req_ready[0], 1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", rsp_valid[0], 0);
        end
        txn(0, 1'b0, 5'd5, 8'h00, 0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 80; n++) begin
            txn(int'($urandom_range(0, 1)), 1'($urandom), 5'($urandom),
                8'($urandom), int'($urandom_range(0, 3)));
        end

        // Read back every word of both instances.
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++)
                txn(k, 1'b0, 5'(a), 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
